// File: rtl/vote_defs.sv
// vote_defs: shared definitions for the weighted ballot session controller.
// Holds the FSM state encoding, the group weights and the ballot widths.
// Also holds the popcount helper that the weighing unit uses.
package vote_defs;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } vote_state_t;

    localparam int W_NP   = 1;
    localparam int W_VIP  = 4;
    localparam int W_VVIP = 16;

    localparam int NP_WIDTH   = 32;
    localparam int VIP_WIDTH  = 8;
    localparam int VVIP_WIDTH = 1;

    // Bit positions of each group in the request, grant and voted vectors.
    localparam int GRP_NP   = 0;
    localparam int GRP_VIP  = 1;
    localparam int GRP_VVIP = 2;

    // Counts the yes bits of a ballot. Narrower ballots are zero-extended by the caller.
    function automatic logic [5:0] popcount(input logic [NP_WIDTH-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < NP_WIDTH; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/vote_ctrl_if.sv
// vote_ctrl_if: session and ballot bus between the ballot sources and vote_ctrl.
// The master side drives requests, ballots, start and close.
// The slave side (the controller) drives the grants, status and result.
interface vote_ctrl_if;
    import vote_defs::*;

    logic                   start;
    logic                   close;
    logic                   np_req;
    logic [NP_WIDTH-1:0]    np_ballot;
    logic                   vip_req;
    logic [VIP_WIDTH-1:0]   vip_ballot;
    logic                   vvip_req;
    logic [VVIP_WIDTH-1:0]  vvip_ballot;
    logic                   np_gnt;
    logic                   vip_gnt;
    logic                   vvip_gnt;
    logic                   busy;
    logic                   done;
    logic [7:0]             res;
    logic                   pass;

    modport master (
        output start, close,
        output np_req, np_ballot, vip_req, vip_ballot, vvip_req, vvip_ballot,
        input  np_gnt, vip_gnt, vvip_gnt,
        input  busy, done, res, pass
    );

    modport slave (
        input  start, close,
        input  np_req, np_ballot, vip_req, vip_ballot, vvip_req, vvip_ballot,
        output np_gnt, vip_gnt, vvip_gnt,
        output busy, done, res, pass
    );

endinterface

// File: rtl/vote_weigh.sv
// vote_weigh: the shared weighing unit.
// Turns the ballot of the selected group into a signed score contribution,
// w*(2p-N) with p the number of yes bits and N the ballot width.
// With no group selected the contribution is zero, so the accumulator can add it blindly.
module vote_weigh
    import vote_defs::*;
(
    input  logic [2:0]             sel,
    input  logic [NP_WIDTH-1:0]    np_ballot,
    input  logic [VIP_WIDTH-1:0]   vip_ballot,
    input  logic [VVIP_WIDTH-1:0]  vvip_ballot,
    output logic signed [7:0]      contrib
);

    logic [5:0] np_yes;
    logic [5:0] vip_yes;

    assign np_yes  = popcount(np_ballot);
    assign vip_yes = popcount({{(NP_WIDTH-VIP_WIDTH){1'b0}}, vip_ballot});

    // Scale and offset the yes count of whichever group holds the grant.
    always_comb begin
        contrib = '0;
        if (sel[GRP_VVIP]) begin
            contrib = 8'(W_VVIP * (2 * int'(vvip_ballot) - VVIP_WIDTH));
        end else if (sel[GRP_VIP]) begin
            contrib = 8'(W_VIP * (2 * int'(vip_yes) - VIP_WIDTH));
        end else if (sel[GRP_NP]) begin
            contrib = 8'(W_NP * (2 * int'(np_yes) - NP_WIDTH));
        end
    end

endmodule

// File: rtl/vote_ctrl.sv
// vote_ctrl: weighted ballot session controller.
// Opens a session on start, grants the three voter groups one at a time onto
// vote_weigh (vvip > vip > np, each group once per session) and accumulates a
// signed score. The session closes when every group has voted, on close, or on
// timeout, and the registered result and verdict are then presented in DONE.
// Build option: define VOTE_TIMEOUT_EN to build the 16-bit session counter and
// the TIMEOUT auto-close; without it a session ends only on all-voted or close.
module vote_ctrl
    import vote_defs::*;
`ifdef VOTE_TIMEOUT_EN
#(
    parameter int TIMEOUT = 64
)
`endif
(
    input  logic       clk,
    input  logic       reset,
    vote_ctrl_if.slave bus
);

    vote_state_t       state_q;
    vote_state_t       state_d;
    logic [2:0]        req_vec;
    logic [2:0]        elig;
    logic [2:0]        gnt;
    logic [2:0]        voted_q;
    logic              all_voted;
    logic              open_session;
    logic              finish;
    logic              timeout_hit;
    logic signed [7:0] acc_q;
    logic signed [7:0] acc_d;
    logic signed [7:0] contrib;
    logic [7:0]        res_q;
    logic              pass_q;

    assign req_vec = {bus.vvip_req, bus.vip_req, bus.np_req};

    // Fixed-priority arbiter over the groups that still have a ballot to cast.
    always_comb begin
        elig = '0;
        gnt  = '0;
        if (state_q == COLLECT) begin
            elig = req_vec & ~voted_q;
        end
        if (elig[GRP_VVIP]) begin
            gnt[GRP_VVIP] = 1'b1;
        end else if (elig[GRP_VIP]) begin
            gnt[GRP_VIP] = 1'b1;
        end else if (elig[GRP_NP]) begin
            gnt[GRP_NP] = 1'b1;
        end
    end

    vote_weigh u_weigh (
        .sel         (gnt),
        .np_ballot   (bus.np_ballot),
        .vip_ballot  (bus.vip_ballot),
        .vvip_ballot (bus.vvip_ballot),
        .contrib     (contrib)
    );

    assign acc_d        = acc_q + contrib;
    assign all_voted    = &(voted_q | gnt);
    assign open_session = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
    assign finish       = (state_q == COLLECT) && (all_voted || bus.close || timeout_hit);

`ifdef VOTE_TIMEOUT_EN
    logic [15:0] cnt_q;

    // Count COLLECT cycles from the opening edge so a stalled session still ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (open_session) begin
            cnt_q <= '0;
        end else if (state_q == COLLECT) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign timeout_hit = (state_q == COLLECT) && (cnt_q == 16'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register; reset aborts any session in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Session sequencing: open from IDLE or DONE, close once any end condition holds.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (finish) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Tally and result registers; a grant on the closing edge is still counted in the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            voted_q <= '0;
            res_q   <= '0;
            pass_q  <= 1'b0;
        end else if (open_session) begin
            acc_q   <= '0;
            voted_q <= '0;
        end else if (state_q == COLLECT) begin
            acc_q   <= acc_d;
            voted_q <= voted_q | gnt;
            if (finish) begin
                res_q  <= acc_d;
                pass_q <= (acc_d > 8'sd0);
            end
        end
    end

    assign bus.np_gnt   = gnt[GRP_NP];
    assign bus.vip_gnt  = gnt[GRP_VIP];
    assign bus.vvip_gnt = gnt[GRP_VVIP];
    assign bus.busy     = (state_q == COLLECT);
    assign bus.done     = (state_q == DONE);
    assign bus.res      = res_q;
    assign bus.pass     = pass_q;

endmodule
